mem_arbiter: RTL and testbench

Shares the CPU's single byte-wide RAM port between the instruction fetcher and the load/store buffer. It arbitrates round-robin between the two requesters and serializes each 1/2/4-byte access into byte cycles on the RAM bus. It assembles little-endian read data and returns one completion pulse per request. It sits between the fetch/LS stages and the external RAM/IO bus.

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide RAM port between instruction fetch and load/store.
// Define MEM_IO_STALL_EN to add io_buffer_full_i back-pressure on writes into the IO region.
module mem_arbiter #(
  parameter logic [1:0] IO_REGION = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr_i,
  input  logic        instEn_i,
  input  logic [31:0] instAddr_i,
  output logic        instRdy_o,
  output logic [31:0] instData_o,
  input  logic        dataEn_i,
  input  logic        dataRw_i,
  input  logic [2:0]  dataWid_i,
  input  logic [31:0] dataAddr_i,
  input  logic [31:0] dataData_i,
  output logic        dataRdy_o,
  output logic [31:0] dataData_o,
`ifdef MEM_IO_STALL_EN
  input  logic        io_buffer_full_i,
`endif
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic        r_last;      // 1 = data was granted last
  logic        r_src;       // 1 = current access belongs to the data port
  logic        r_rw;
  logic [2:0]  r_wid;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [2:0]  r_k;
  logic        r_flush;
  logic        r_wr;
  logic [31:0] r_a;
  logic [7:0]  r_dout;
  logic        r_inst_rdy;
  logic        r_data_rdy;
  logic [31:0] r_inst_data;
  logic [31:0] r_data_data;

  function automatic logic io_stall(input logic [1:0] region);
`ifdef MEM_IO_STALL_EN
    return io_buffer_full_i && (region == IO_REGION);
`else
    return 1'b0 & (region == IO_REGION);
`endif
  endfunction

  logic        w_gnt_data;
  logic [2:0]  w_wid;
  logic [31:0] w_req_addr;
  logic        w_req_wr;
  logic [31:0] w_byte_addr;
  logic [4:0]  w_shift;
  logic [4:0]  w_wsel;
  logic [31:0] w_rdata;

  assign w_gnt_data  = dataEn_i & (~instEn_i | ~r_last);
  assign w_wid       = (dataWid_i == 3'd1) ? 3'd1 : (dataWid_i == 3'd2) ? 3'd2 : 3'd4;
  assign w_req_addr  = w_gnt_data ? dataAddr_i : instAddr_i;
  assign w_req_wr    = w_gnt_data & dataRw_i;
  assign w_byte_addr = r_addr + {29'd0, r_k};
  // In a read, r_k is the edge index since grant; byte r_k-2 arrives on mem_din_i now.
  assign w_shift     = {r_k[1:0] - 2'd2, 3'b000};
  assign w_wsel      = {r_k[1:0], 3'b000};
  assign w_rdata     = r_rdata | ({24'd0, mem_din_i} << w_shift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b0;
      r_src       <= 1'b0;
      r_rw        <= 1'b0;
      r_wid       <= 3'd4;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_k         <= 3'd0;
      r_flush     <= 1'b0;
      r_wr        <= 1'b0;
      r_a         <= 32'd0;
      r_dout      <= 8'd0;
      r_inst_rdy  <= 1'b0;
      r_data_rdy  <= 1'b0;
      r_inst_data <= 32'd0;
      r_data_data <= 32'd0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (!clr_i && (instEn_i || dataEn_i)) begin
            r_state <= S_BUSY;
            r_last  <= w_gnt_data;
            r_src   <= w_gnt_data;
            r_rw    <= w_req_wr;
            r_wid   <= w_gnt_data ? w_wid : 3'd4;
            r_addr  <= w_req_addr;
            r_wdata <= dataData_i;
            r_rdata <= 32'd0;
            r_flush <= 1'b0;
            r_a     <= w_req_addr;
            if (w_req_wr && io_stall(w_req_addr[17:16])) begin
              r_k  <= 3'd0;
              r_wr <= 1'b0;
            end else begin
              r_k  <= 3'd1;
              r_wr <= w_req_wr;
              if (w_req_wr) r_dout <= dataData_i[7:0];
            end
          end
        end
        S_BUSY: begin
          if (r_rw) begin
            // Writes always run to completion; a flush only hides the completion pulse.
            if (clr_i) r_flush <= 1'b1;
            if (r_k == r_wid) begin
              r_wr       <= 1'b0;
              r_data_rdy <= !(r_flush || clr_i);
              r_state    <= S_DONE;
            end else begin
              r_a <= w_byte_addr;
              if (io_stall(w_byte_addr[17:16])) begin
                r_wr <= 1'b0;
              end else begin
                r_wr   <= 1'b1;
                r_dout <= r_wdata[w_wsel +: 8];
                r_k    <= r_k + 3'd1;
              end
            end
          end else if (clr_i) begin
            r_state <= S_IDLE;
          end else begin
            if (r_k < r_wid) r_a <= w_byte_addr;
            if (r_k >= 3'd2) r_rdata <= w_rdata;
            if (r_k == r_wid + 3'd1) begin
              r_state <= S_DONE;
              if (r_src) begin
                r_data_rdy  <= 1'b1;
                r_data_data <= w_rdata;
              end else begin
                r_inst_rdy  <= 1'b1;
                r_inst_data <= w_rdata;
              end
            end
            r_k <= r_k + 3'd1;
          end
        end
        default: begin
          r_inst_rdy <= 1'b0;
          r_data_rdy <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign instRdy_o  = r_inst_rdy;
  assign instData_o = r_inst_data;
  assign dataRdy_o  = r_data_rdy;
  assign dataData_o = r_data_data;
  assign mem_a_o    = r_a;
  assign mem_dout_o = r_dout;
  assign mem_wr_o   = r_wr & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, shadow memory reference, directed and random traffic.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, clr_i;
  logic        instEn_i, dataEn_i, dataRw_i;
  logic [31:0] instAddr_i, dataAddr_i, dataData_i;
  logic [2:0]  dataWid_i;
  logic        instRdy_o, dataRdy_o, mem_wr_o;
  logic [31:0] instData_o, dataData_o, mem_a_o;
  logic [7:0]  mem_din_i, mem_dout_o;
`ifdef MEM_IO_STALL_EN
  logic        io_full;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.IO_REGION(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
    .instEn_i(instEn_i), .instAddr_i(instAddr_i), .instRdy_o(instRdy_o), .instData_o(instData_o),
    .dataEn_i(dataEn_i), .dataRw_i(dataRw_i), .dataWid_i(dataWid_i), .dataAddr_i(dataAddr_i),
    .dataData_i(dataData_i), .dataRdy_o(dataRdy_o), .dataData_o(dataData_o),
`ifdef MEM_IO_STALL_EN
    .io_buffer_full_i(io_full),
`endif
    .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
  );

  typedef struct {logic rw; logic [31:0] val;} dexp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ram    [logic [31:0]];
  logic [7:0]  shadow [logic [31:0]];
  logic [31:0] instq[$];
  dexp_t       dataq[$];
  logic [39:0] wq[$];
  logic        rdy_edge = 1'b1;
  logic        ia_done, da_done;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [2:0] w);
    return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
  endfunction

  // Little-endian, zero-filled, address wraps at 2^32.
  function automatic logic [31:0] exp_read(input logic [31:0] a, input int n);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = sh_rd(a + 32'(k));
    return v;
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    shadow[a] = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic inst_req(input logic [31:0] a, output int lat);
    while (instRdy_o) begin @(posedge clk); #1; end
    instq.push_back(exp_read(a, 4));
    instAddr_i = a;
    instEn_i   = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!instRdy_o && lat < 400);
    if (!instRdy_o) check32("inst_timeout", 32'd0, 32'd1);
    instEn_i = 1'b0;
  endtask

  task automatic data_req(input logic rw, input logic [2:0] wid, input logic [31:0] a,
                          input logic [31:0] wd, output int lat);
    int n;
    while (dataRdy_o) begin @(posedge clk); #1; end
    n = nbytes(wid);
    if (rw) begin
      for (int k = 0; k < n; k++) begin
        shadow[a + 32'(k)] = wd[8*k +: 8];
        wq.push_back({a + 32'(k), wd[8*k +: 8]});
      end
      dataq.push_back('{rw: 1'b1, val: 32'd0});
    end else begin
      dataq.push_back('{rw: 1'b0, val: exp_read(a, n)});
    end
    dataRw_i = rw; dataWid_i = wid; dataAddr_i = a; dataData_i = wd;
    dataEn_i = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!dataRdy_o && lat < 400);
    if (!dataRdy_o) check32("data_timeout", 32'd0, 32'd1);
    dataEn_i = 1'b0;
  endtask

  // External RAM: captures the address on an enabled edge and presents that byte until the next.
  initial begin
    mem_din_i = 8'd0;
    forever begin
      @(posedge clk);
      rdy_edge = rdy;
      if (rdy && !rst) begin
        mem_din_i <= ram.exists(mem_a_o) ? ram[mem_a_o] : init_byte(mem_a_o);
        if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
      end
    end
  end

  // Monitor: one completion per pulse; a pulse frozen by rdy low counts once.
  initial begin
    logic  pi, pd;
    dexp_t de;
    logic [31:0] ie;
    logic [39:0] we;
    pi = 1'b0; pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pi = 1'b0; pd = 1'b0;
      end else begin
        if (instRdy_o || dataRdy_o) check32("one_rdy", {31'd0, instRdy_o & dataRdy_o}, 32'd0);
        if (instRdy_o && (!pi || rdy_edge)) begin
          if (instq.size() == 0) check32("inst_unexpected", 32'd1, 32'd0);
          else begin ie = instq.pop_front(); check32("inst_data", instData_o, ie); end
        end
        if (dataRdy_o && (!pd || rdy_edge)) begin
          if (dataq.size() == 0) check32("data_unexpected", 32'd1, 32'd0);
          else begin
            de = dataq.pop_front();
            if (!de.rw) check32("data_load", dataData_o, de.val);
          end
        end
        if (mem_wr_o) begin
          if (wq.size() == 0) check32("wr_unexpected", mem_a_o, 32'hFFFF_FFFF);
          else begin
            we = wq.pop_front();
            check32("wr_addr", mem_a_o, we[39:8]);
            check32("wr_byte", {24'd0, mem_dout_o}, {24'd0, we[7:0]});
          end
        end
        pi = instRdy_o; pd = dataRdy_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat, ilat, dlat, seen, got;
    int ord[4];
    logic [31:0] a;
    logic [2:0]  wsel[5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0};
    rst = 1'b1; rdy = 1'b1; clr_i = 1'b0;
    instEn_i = 1'b0; instAddr_i = 32'd0;
    dataEn_i = 1'b0; dataRw_i = 1'b0; dataWid_i = 3'd4; dataAddr_i = 32'd0; dataData_i = 32'd0;
`ifdef MEM_IO_STALL_EN
    io_full = 1'b0;
`endif
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05); poke(32'h1002, 8'h10); poke(32'h1003, 8'h00);
    poke(32'h2002, 8'hFE); poke(32'h2003, 8'h80);
    repeat (3) @(posedge clk);
    #1;
    check32("rst_mem_a", mem_a_o, 32'd0);
    check32("rst_mem_wr", {31'd0, mem_wr_o}, 32'd0);
    check32("rst_rdys", {30'd0, instRdy_o, dataRdy_o}, 32'd0);
    check32("rst_inst_data", instData_o, 32'd0);
    check32("rst_data_data", dataData_o, 32'd0);
    rst = 1'b0;
    idle(2);

    inst_req(32'h1000, lat);
    check32("fetch_latency", lat, 6);
    check32("fetch_word", instData_o, 32'h0010_0513);
    idle(2);
    data_req(1'b0, 3'd2, 32'h2002, 32'd0, lat);
    check32("lh_latency", lat, 4);
    check32("lh_value", dataData_o, 32'h0000_80FE);
    idle(2);
    data_req(1'b1, 3'd4, 32'h3000, 32'hDEAD_BEEF, lat);
    check32("sw_latency", lat, 5);
    check32("sw_done_wr_low", {31'd0, mem_wr_o}, 32'd0);
    idle(2);
    data_req(1'b0, 3'd4, 32'h3000, 32'd0, lat);
    data_req(1'b0, 3'd4, 32'hFFFF_FFFE, 32'd0, lat);
    data_req(1'b0, 3'd3, 32'h0002_0020, 32'd0, lat);
    data_req(1'b0, 3'd1, 32'h3001, 32'd0, lat);
    idle(2);

    // Flush during a fetch: sampled at t2, no completion.
    instAddr_i = 32'h1000; instEn_i = 1'b1;
    idle(2);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0; instEn_i = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (instRdy_o) seen++; end
    check32("flush_fetch_no_rdy", seen, 0);

    // Flush during a store: sampled at t1, all bytes still written, no completion.
    for (int k = 0; k < 4; k++) begin
      shadow[32'h0002_0040 + 32'(k)] = 8'h60 + 8'(k);
      wq.push_back({32'h0002_0040 + 32'(k), 8'h60 + 8'(k)});
    end
    dataRw_i = 1'b1; dataWid_i = 3'd4; dataAddr_i = 32'h0002_0040; dataData_i = 32'h6362_6160;
    dataEn_i = 1'b1;
    idle(1);
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0; dataEn_i = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (dataRdy_o) seen++; end
    check32("flush_sw_no_rdy", seen, 0);
    check32("flush_sw_bytes", wq.size(), 0);
    data_req(1'b0, 3'd4, 32'h0002_0040, 32'd0, lat);
    inst_req(32'h1000, lat);
    idle(2);

`ifdef MEM_IO_STALL_EN
    fork
      data_req(1'b1, 3'd1, 32'h0003_0000, 32'h0000_00A7, lat);
      begin io_full = 1'b1; repeat (3) @(posedge clk); #1; io_full = 1'b0; end
    join
    check32("io_stall_latency", lat, 5);
    idle(2);
`endif

    // Randomized concurrent traffic with global enable toggling.
    ia_done = 1'b0; da_done = 1'b0;
    fork
      begin
        repeat (30) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          a = $urandom; a[17:16] = 2'b00; a[15:12] = 4'h8;
          inst_req(a, ilat);
        end
        ia_done = 1'b1;
      end
      begin
        repeat (40) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          data_req(1'($urandom_range(0, 1)), wsel[$urandom_range(0, 4)],
                   32'h0002_0000 + 32'($urandom_range(0, 255)), $urandom, dlat);
        end
        da_done = 1'b1;
      end
      begin
        while (!(ia_done && da_done)) begin
          @(posedge clk); #1;
          rdy = ($urandom_range(0, 4) != 0);
        end
        rdy = 1'b1;
      end
    join
    idle(4);

    // Asynchronous reset in the middle of a store.
    for (int k = 0; k < 4; k++) wq.push_back({32'h0002_1000 + 32'(k), 8'h11 * 8'(k + 1)});
    dataRw_i = 1'b1; dataWid_i = 3'd4; dataAddr_i = 32'h0002_1000; dataData_i = 32'h4433_2211;
    dataEn_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check32("mid_rst_mem_a", mem_a_o, 32'd0);
    check32("mid_rst_dout", {24'd0, mem_dout_o}, 32'd0);
    check32("mid_rst_wr", {31'd0, mem_wr_o}, 32'd0);
    check32("mid_rst_rdys", {30'd0, instRdy_o, dataRdy_o}, 32'd0);
    check32("mid_rst_inst_data", instData_o, 32'd0);
    check32("mid_rst_data_data", dataData_o, 32'd0);
    dataEn_i = 1'b0;
    wq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Both requesters held: first tie goes to data, then strict alternation.
    instq.push_back(exp_read(32'h1000, 4));
    instq.push_back(exp_read(32'h1000, 4));
    dataq.push_back('{rw: 1'b0, val: exp_read(32'h0002_0010, 4)});
    dataq.push_back('{rw: 1'b0, val: exp_read(32'h0002_0010, 4)});
    instAddr_i = 32'h1000;
    dataRw_i = 1'b0; dataWid_i = 3'd4; dataAddr_i = 32'h0002_0010;
    instEn_i = 1'b1; dataEn_i = 1'b1;
    got = 0; seen = 0;
    while (got < 4 && seen < 200) begin
      @(posedge clk); #1; seen++;
      if (instRdy_o) begin ord[got] = 0; got++; end
      if (dataRdy_o) begin ord[got] = 1; got++; end
    end
    instEn_i = 1'b0; dataEn_i = 1'b0;
    check32("rr_count", got, 4);
    for (int i = 0; i < 4; i++) check32("rr_order", ord[i], (i % 2 == 0) ? 1 : 0);

    idle(10);
    check32("instq_empty", instq.size(), 0);
    check32("dataq_empty", dataq.size(), 0);
    check32("wq_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
